// File: rtl/sm_directory_if.sv
// Request channel from the caches into the directory controller.
// Valid/ready handshake carrying the message type and requesting node.
interface sm_directory_if #(
  parameter int NODE_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_type;
  logic [NODE_W-1:0] req_node;

  modport master (
    output req_valid,
    output req_type,
    output req_node,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_type,
    input  req_node,
    output req_ready
  );
endinterface

// File: rtl/sm_directory.sv
// MSI directory controller for a single memory block.
// Tracks global state and sharers; fetches from owner on conflicts.
module sm_directory #(
  parameter int NODES  = 4,
  parameter int NODE_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  sm_directory_if.slave     req,
  input  logic              wb_valid,
  input  logic [NODE_W-1:0] wb_node,
  output logic [NODES-1:0]  fetch,
  output logic [NODES-1:0]  invalidate,
  output logic              reply_valid,
  output logic [NODE_W-1:0] reply_node,
  output logic              mem_write,
  output logic [1:0]        dir_state,
  output logic [NODES-1:0]  sharers,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    WAIT_WB
  } ctrl_t;

  typedef enum logic [1:0] {
    UNC = 2'b00,
    SHR = 2'b01,
    EXC = 2'b10
  } dir_t;

  localparam logic [1:0] T_RD = 2'b00;
  localparam logic [1:0] T_WB = 2'b11;

  ctrl_t             ctrl;
  dir_t              dir;
  logic [NODE_W-1:0] pend_node;
  logic              pend_write;

  logic [NODES-1:0]  n_bit;
  logic [NODES-1:0]  wb_bit;
  logic [NODES-1:0]  p_bit;
  logic              own_req;
  logic              wb_hit;
  logic              is_rd;
  logic              is_wb;
  logic              accept;

  function automatic logic [NODES-1:0] bit_of(
    input logic [NODE_W-1:0] id
  );
    logic [NODES-1:0] v;
    for (int i = 0; i < NODES; i++) begin
      v[i] = (id == NODE_W'(i));
    end
    return v;
  endfunction

  assign n_bit   = bit_of(req.req_node);
  assign wb_bit  = bit_of(wb_node);
  assign p_bit   = bit_of(pend_node);
  // Owner is the sole set bit of sharers while Exclusive.
  assign own_req = |(sharers & n_bit);
  assign wb_hit  = |(sharers & wb_bit);
  assign is_rd   = (req.req_type == T_RD);
  assign is_wb   = (req.req_type == T_WB);
  assign accept  = req.req_valid && (ctrl == IDLE);

  assign req.req_ready = (ctrl == IDLE);
  assign busy          = (ctrl == WAIT_WB);
  assign dir_state     = dir;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctrl        <= IDLE;
      dir         <= UNC;
      sharers     <= '0;
      fetch       <= '0;
      invalidate  <= '0;
      reply_valid <= 1'b0;
      reply_node  <= '0;
      mem_write   <= 1'b0;
      pend_node   <= '0;
      pend_write  <= 1'b0;
    end else begin
      fetch       <= '0;
      invalidate  <= '0;
      reply_valid <= 1'b0;
      mem_write   <= 1'b0;
      unique case (ctrl)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              (dir == UNC): begin
                if (!is_wb) begin
                  reply_valid <= 1'b1;
                  reply_node  <= req.req_node;
                  sharers     <= n_bit;
                  dir         <= is_rd ? SHR : EXC;
                end
              end
              (dir == SHR): begin
                if (is_rd) begin
                  reply_valid <= 1'b1;
                  reply_node  <= req.req_node;
                  sharers     <= sharers | n_bit;
                end else if (!is_wb) begin
                  invalidate  <= sharers & ~n_bit;
                  reply_valid <= 1'b1;
                  reply_node  <= req.req_node;
                  sharers     <= n_bit;
                  dir         <= EXC;
                end
              end
              (dir == EXC && own_req): begin
                if (is_wb) begin
                  mem_write <= 1'b1;
                  sharers   <= '0;
                  dir       <= UNC;
                end else begin
                  reply_valid <= 1'b1;
                  reply_node  <= req.req_node;
                  if (is_rd) begin
                    sharers <= n_bit;
                    dir     <= SHR;
                  end
                end
              end
              (dir == EXC && !own_req): begin
                // Stale writeBack from a non-owner is dropped.
                if (!is_wb) begin
                  fetch      <= sharers;
                  invalidate <= is_rd ? '0 : sharers;
                  pend_node  <= req.req_node;
                  pend_write <= !is_rd;
                  ctrl       <= WAIT_WB;
                end
              end
              default: ;
            endcase
          end
        end
        WAIT_WB: begin
          if (wb_valid && wb_hit) begin
            mem_write   <= 1'b1;
            reply_valid <= 1'b1;
            reply_node  <= pend_node;
            ctrl        <= IDLE;
            if (pend_write) begin
              sharers <= p_bit;
              dir     <= EXC;
            end else begin
              sharers <= sharers | p_bit;
              dir     <= SHR;
            end
          end
        end
        default: ctrl <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_directory.sv
// Directed self-checking bench for the MSI directory controller.
// Each task drives one scenario and checks registered outputs.
module tb_sm_directory;

  localparam logic [1:0] RD  = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] INV = 2'b10;
  localparam logic [1:0] WB  = 2'b11;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       wb_valid = 1'b0;
  logic [1:0] wb_node = 2'd0;
  logic [3:0] fetch;
  logic [3:0] invalidate;
  logic       reply_valid;
  logic [1:0] reply_node;
  logic       mem_write;
  logic [1:0] dir_state;
  logic [3:0] sharers;
  logic       busy;

  int checks = 0;
  int errors = 0;

  sm_directory_if #(.NODE_W(2)) rq ();

  sm_directory #(
    .NODES (4),
    .NODE_W(2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (rq),
    .wb_valid   (wb_valid),
    .wb_node    (wb_node),
    .fetch      (fetch),
    .invalidate (invalidate),
    .reply_valid(reply_valid),
    .reply_node (reply_node),
    .mem_write  (mem_write),
    .dir_state  (dir_state),
    .sharers    (sharers),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] t, input logic [1:0] n);
    rq.req_valid = 1'b1;
    rq.req_type  = t;
    rq.req_node  = n;
    tick();
    rq.req_valid = 1'b0;
  endtask

  task automatic send_wb(input logic [1:0] n);
    wb_valid = 1'b1;
    wb_node  = n;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rq.req_valid = 1'b1;
    rq.req_type  = RD;
    rq.req_node  = 2'd1;
    tick();
    tick();
    checks++;
    if ({dir_state, sharers} !== 6'b00_0000) begin
      errors++;
      $display("FAIL reset_state: got %b/%b want 00/0000",
               dir_state, sharers);
    end
    checks++;
    if ({reply_valid, reply_node, fetch, invalidate, mem_write}
        !== 12'b0) begin
      errors++;
      $display("FAIL reset_pulses: rv=%b rn=%0d f=%b i=%b mw=%b",
               reply_valid, reply_node, fetch, invalidate, mem_write);
    end
    checks++;
    if ({rq.req_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/busy=%b%b want 10",
               rq.req_ready, busy);
    end
    rq.req_valid = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_read_shared();
    send(RD, 2'd1);
    checks++;
    if ({reply_valid, reply_node, dir_state, sharers}
        !== {1'b1, 2'd1, 2'b01, 4'b0010}) begin
      errors++;
      $display("FAIL rd_n1: rv=%b rn=%0d st=%b sh=%b want 1/1/01/0010",
               reply_valid, reply_node, dir_state, sharers);
    end
    send(RD, 2'd2);
    checks++;
    if ({reply_valid, reply_node, dir_state, sharers, rq.req_ready}
        !== {1'b1, 2'd2, 2'b01, 4'b0110, 1'b1}) begin
      errors++;
      $display("FAIL rd_n2: rv=%b rn=%0d st=%b sh=%b rdy=%b",
               reply_valid, reply_node, dir_state, sharers, rq.req_ready);
    end
    tick();
    checks++;
    if ({reply_valid, reply_node} !== {1'b0, 2'd2}) begin
      errors++;
      $display("FAIL reply_hold: rv=%b rn=%0d want 0/2",
               reply_valid, reply_node);
    end
  endtask

  task automatic test_write_invalidate();
    send(WR, 2'd3);
    checks++;
    if ({invalidate, fetch, reply_valid, reply_node}
        !== {4'b0110, 4'b0000, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL wr_n3: inv=%b f=%b rv=%b rn=%0d want 0110/0000/1/3",
               invalidate, fetch, reply_valid, reply_node);
    end
    checks++;
    if ({dir_state, sharers} !== {2'b10, 4'b1000}) begin
      errors++;
      $display("FAIL wr_n3_state: got %b/%b want 10/1000",
               dir_state, sharers);
    end
    tick();
    checks++;
    if ({invalidate, reply_valid} !== 5'b0) begin
      errors++;
      $display("FAIL inv_width: inv=%b rv=%b want 0000/0",
               invalidate, reply_valid);
    end
  endtask

  task automatic test_fetch_read();
    send(RD, 2'd0);
    checks++;
    if ({fetch, invalidate, busy, rq.req_ready, reply_valid}
        !== {4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fetch_rd: f=%b i=%b busy=%b rdy=%b rv=%b",
               fetch, invalidate, busy, rq.req_ready, reply_valid);
    end
    send_wb(2'd2);
    checks++;
    if ({fetch, busy, mem_write, reply_valid, dir_state}
        !== {4'b0000, 1'b1, 1'b0, 1'b0, 2'b10}) begin
      errors++;
      $display("FAIL stray_wb: f=%b busy=%b mw=%b rv=%b st=%b",
               fetch, busy, mem_write, reply_valid, dir_state);
    end
    send_wb(2'd3);
    checks++;
    if ({mem_write, reply_valid, reply_node, rq.req_ready, busy}
        !== {1'b1, 1'b1, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wb_match: mw=%b rv=%b rn=%0d rdy=%b busy=%b",
               mem_write, reply_valid, reply_node, rq.req_ready, busy);
    end
    checks++;
    if ({dir_state, sharers} !== {2'b01, 4'b1001}) begin
      errors++;
      $display("FAIL wb_match_state: got %b/%b want 01/1001",
               dir_state, sharers);
    end
  endtask

  task automatic test_fetch_write();
    send(WR, 2'd2);
    checks++;
    if ({invalidate, dir_state, sharers}
        !== {4'b1001, 2'b10, 4'b0100}) begin
      errors++;
      $display("FAIL wr_n2: inv=%b st=%b sh=%b want 1001/10/0100",
               invalidate, dir_state, sharers);
    end
    send(WR, 2'd1);
    checks++;
    if ({fetch, invalidate, busy, reply_valid}
        !== {4'b0100, 4'b0100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fetch_wr: f=%b i=%b busy=%b rv=%b want 0100/0100/1/0",
               fetch, invalidate, busy, reply_valid);
    end
    send_wb(2'd2);
    checks++;
    if ({mem_write, reply_valid, reply_node, dir_state, sharers}
        !== {1'b1, 1'b1, 2'd1, 2'b10, 4'b0010}) begin
      errors++;
      $display("FAIL wb_wr: mw=%b rv=%b rn=%0d st=%b sh=%b",
               mem_write, reply_valid, reply_node, dir_state, sharers);
    end
  endtask

  task automatic test_owner_ops();
    send(WB, 2'd0);
    checks++;
    if ({mem_write, reply_valid, fetch, dir_state, sharers}
        !== {1'b0, 1'b0, 4'b0000, 2'b10, 4'b0010}) begin
      errors++;
      $display("FAIL stale_wb: mw=%b rv=%b f=%b st=%b sh=%b",
               mem_write, reply_valid, fetch, dir_state, sharers);
    end
    send(WR, 2'd1);
    checks++;
    if ({reply_valid, reply_node, fetch, busy, dir_state, sharers}
        !== {1'b1, 2'd1, 4'b0000, 1'b0, 2'b10, 4'b0010}) begin
      errors++;
      $display("FAIL owner_wr: rv=%b rn=%0d f=%b busy=%b st=%b sh=%b",
               reply_valid, reply_node, fetch, busy, dir_state, sharers);
    end
    send(WB, 2'd1);
    checks++;
    if ({mem_write, reply_valid, dir_state, sharers}
        !== {1'b1, 1'b0, 2'b00, 4'b0000}) begin
      errors++;
      $display("FAIL owner_wb: mw=%b rv=%b st=%b sh=%b want 1/0/00/0000",
               mem_write, reply_valid, dir_state, sharers);
    end
    send(WB, 2'd2);
    send_wb(2'd1);
    checks++;
    if ({mem_write, reply_valid, dir_state, sharers}
        !== {1'b0, 1'b0, 2'b00, 4'b0000}) begin
      errors++;
      $display("FAIL unc_wb: mw=%b rv=%b st=%b sh=%b want 0/0/00/0000",
               mem_write, reply_valid, dir_state, sharers);
    end
  endtask

  task automatic test_sole_sharer();
    send(INV, 2'd2);
    checks++;
    if ({reply_valid, dir_state, sharers} !== {1'b1, 2'b10, 4'b0100}) begin
      errors++;
      $display("FAIL unc_inv: rv=%b st=%b sh=%b want 1/10/0100",
               reply_valid, dir_state, sharers);
    end
    send(RD, 2'd2);
    checks++;
    if ({reply_valid, dir_state, sharers} !== {1'b1, 2'b01, 4'b0100}) begin
      errors++;
      $display("FAIL owner_rd: rv=%b st=%b sh=%b want 1/01/0100",
               reply_valid, dir_state, sharers);
    end
    send(INV, 2'd2);
    checks++;
    if ({invalidate, reply_valid, dir_state, sharers}
        !== {4'b0000, 1'b1, 2'b10, 4'b0100}) begin
      errors++;
      $display("FAIL sole_inv: inv=%b rv=%b st=%b sh=%b",
               invalidate, reply_valid, dir_state, sharers);
    end
  endtask

  task automatic test_reset_wait();
    send(RD, 2'd0);
    checks++;
    if ({fetch, busy} !== {4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL pre_abort: f=%b busy=%b want 0100/1", fetch, busy);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({dir_state, sharers, rq.req_ready, busy, reply_valid}
        !== {2'b00, 4'b0000, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort: st=%b sh=%b rdy=%b busy=%b rv=%b",
               dir_state, sharers, rq.req_ready, busy, reply_valid);
    end
    send_wb(2'd2);
    checks++;
    if ({mem_write, reply_valid, dir_state, sharers}
        !== {1'b0, 1'b0, 2'b00, 4'b0000}) begin
      errors++;
      $display("FAIL late_wb: mw=%b rv=%b st=%b sh=%b",
               mem_write, reply_valid, dir_state, sharers);
    end
  endtask

  initial begin
    rq.req_valid = 1'b0;
    rq.req_type  = RD;
    rq.req_node  = 2'd0;
    test_reset();
    test_read_shared();
    test_write_invalidate();
    test_fetch_read();
    test_fetch_write();
    test_owner_ops();
    test_sole_sharer();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
